// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared constants and helpers for the key debouncer slice.
//   NUM_KEYS_DEFAULT      : default number of key channels
//   STABLE_CYCLES_DEFAULT : default acceptance window (10 ms at 50 MHz)
//   key_level_e           : debounced key level encoding
//   cnt_width()           : stability-counter width for a given window
// No ports (package).
// ---------------------------------------------------------------------------
package key_pkg;

  localparam int unsigned NUM_KEYS_DEFAULT      = 4;
  localparam int unsigned STABLE_CYCLES_DEFAULT = 500000;

  typedef enum logic {
    KEY_UP   = 1'b0,
    KEY_DOWN = 1'b1
  } key_level_e;

  // Counter must be able to hold 0..STABLE_CYCLES-1; clog2(N+1) bits keeps
  // the width at least 1 even for a one-cycle window.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// ---------------------------------------------------------------------------
// key_debouncer_if
// Key bundle between push-button pads and the debouncer.
//   key_n        : raw active-low push-button levels (driven by master)
//   key          : debounced active-high levels (driven by slave)
//   key_released : one-cycle release pulses (driven by slave)
// Modports: master = key source / consumer side, slave = debouncer.
// ---------------------------------------------------------------------------
interface key_debouncer_if
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS = NUM_KEYS_DEFAULT
);

  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key;
  logic [NUM_KEYS-1:0] key_released;

  modport master (
    output key_n,
    input  key,
    input  key_released
  );

  modport slave (
    input  key_n,
    output key,
    output key_released
  );

endinterface

// File: rtl/key_debounce_channel.sv
// ---------------------------------------------------------------------------
// key_debounce_channel
// One debounced key: 2-flop synchroniser on the inverted raw level, a
// stability counter, the accepted-level flop and an optional release pulse.
//   clock        : sole clock, rising edge
//   reset_n      : asynchronous active-low reset
//   key_n        : raw active-low key level (asynchronous)
//   key          : debounced active-high level (registered)
//   key_released : one-cycle pulse the cycle after key falls 1->0
// Optional feature macro: KEY_DEBOUNCER_RELEASE_PULSE_EN
//   (undefined: key_released is tied to 0 and no release logic exists).
// ---------------------------------------------------------------------------
module key_debounce_channel
  import key_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic key,
  output logic key_released
);

  localparam int unsigned   CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic           sync_meta;
  logic           sync;
  logic [CW-1:0]  cnt;
  key_level_e     level;

  // Inversion happens before the first flop so reset (0) means released.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= ~key_n;
      sync      <= sync_meta;
    end
  end

  // Any cycle where the synchronised level matches the accepted level
  // restarts the window; the counter saturates at CNT_MAX by accepting.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= KEY_UP;
    end else if (key_level_e'(sync) == level) begin
      cnt   <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt   <= '0;
      level <= key_level_e'(sync);
    end else begin
      cnt   <= cnt + CW'(1);
    end
  end

  assign key = (level == KEY_DOWN);

`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
  logic key_dly;

  // Pulse is registered off the delayed level, so it lands one cycle
  // after key has already dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_dly      <= 1'b0;
      key_released <= 1'b0;
    end else begin
      key_dly      <= key;
      key_released <= key_dly & ~key;
    end
  end
`else
  assign key_released = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// ---------------------------------------------------------------------------
// key_debouncer
// NUM_KEYS independent push-button debouncers.
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : key_debouncer_if.slave
//             key_n (in, raw active-low), key (out, debounced active-high),
//             key_released (out, one-cycle release pulses)
// Parameters: NUM_KEYS (channels), STABLE_CYCLES (1 .. 2^24-1 cycles a
// change must persist before it is accepted).
// Optional feature macro: KEY_DEBOUNCER_RELEASE_PULSE_EN enables the
// key_released pulses; otherwise key_released is constant 0.
// ---------------------------------------------------------------------------
module key_debouncer
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS      = NUM_KEYS_DEFAULT,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  key_debouncer_if.slave  bus
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clock        (clock),
      .reset_n      (reset_n),
      .key_n        (bus.key_n[i]),
      .key          (bus.key[i]),
      .key_released (bus.key_released[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// ---------------------------------------------------------------------------
// tb_key_debouncer
// Directed self-checking bench for key_debouncer (STABLE_CYCLES = 4,
// NUM_KEYS = 4) plus a single-key instance with STABLE_CYCLES = 1.
// Inputs change and outputs are sampled 1 time unit after a rising edge,
// so "after edge N" means N rising edges after the input change.
// ---------------------------------------------------------------------------
module tb_key_debouncer;

`ifdef KEY_DEBOUNCER_RELEASE_PULSE_EN
  localparam logic [3:0] REL0 = 4'b0001;
`else
  localparam logic [3:0] REL0 = 4'b0000;
`endif

  logic clock;
  logic reset_n;
  int   tests_run;
  int   failed;

  key_debouncer_if #(.NUM_KEYS(4)) bus ();
  key_debouncer_if #(.NUM_KEYS(1)) bus1 ();

  key_debouncer #(
    .NUM_KEYS      (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  key_debouncer #(
    .NUM_KEYS      (1),
    .STABLE_CYCLES (1)
  ) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] kn);
    bus.key_n  = kn;
    bus1.key_n = 1'b1;
    reset_n    = 1'b0;
    tick(2);
    reset_n    = 1'b1;
  endtask

  task automatic test_reset();
    bus.key_n  = 4'b0000;
    bus1.key_n = 1'b1;
    reset_n    = 1'b0;
    #1;
    tests_run++;
    if (bus.key !== 4'b0000) begin
      failed++; $display("FAIL reset_async key: got %b expected %b", bus.key, 4'b0000);
    end
    tick(3);
    tests_run++;
    if (bus.key !== 4'b0000 || bus.key_released !== 4'b0000) begin
      failed++; $display("FAIL reset_hold: key=%b rel=%b expected 0000/0000", bus.key, bus.key_released);
    end
    reset_n = 1'b1;
    tick(5);
    tests_run++;
    if (bus.key !== 4'b0000) begin
      failed++; $display("FAIL reset_rel_edge5: key=%b expected %b", bus.key, 4'b0000);
    end
    tick(1);
    tests_run++;
    if (bus.key !== 4'b1111) begin
      failed++; $display("FAIL reset_rel_edge6: key=%b expected %b", bus.key, 4'b1111);
    end
  endtask

  task automatic test_clean_press();
    apply_reset(4'b1111);
    bus.key_n = 4'b1110;
    tick(5);
    tests_run++;
    if (bus.key !== 4'b0000) begin
      failed++; $display("FAIL press_edge5: key=%b expected %b", bus.key, 4'b0000);
    end
    tick(1);
    tests_run++;
    if (bus.key !== 4'b0001) begin
      failed++; $display("FAIL press_edge6: key=%b expected %b", bus.key, 4'b0001);
    end
    tick(4);
    tests_run++;
    if (bus.key !== 4'b0001 || bus.key_released !== 4'b0000) begin
      failed++; $display("FAIL press_hold: key=%b rel=%b expected 0001/0000", bus.key, bus.key_released);
    end
  endtask

  task automatic test_glitch();
    apply_reset(4'b1111);
    bus.key_n = 4'b1101;
    tick(3);
    bus.key_n = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      tests_run++;
      if (bus.key !== 4'b0000) begin
        failed++; $display("FAIL glitch_cycle%0d: key=%b expected %b", i, bus.key, 4'b0000);
      end
    end
    bus.key_n = 4'b1101;
    tick(5);
    tests_run++;
    if (bus.key !== 4'b0000) begin
      failed++; $display("FAIL glitch_relow_edge5: key=%b expected %b", bus.key, 4'b0000);
    end
    tick(1);
    tests_run++;
    if (bus.key !== 4'b0010) begin
      failed++; $display("FAIL glitch_relow_edge6: key=%b expected %b", bus.key, 4'b0010);
    end
  endtask

  task automatic test_staggered();
    logic [3:0] exp_key [0:3];
    exp_key[0] = 4'b0000;
    exp_key[1] = 4'b0100;
    exp_key[2] = 4'b0100;
    exp_key[3] = 4'b1100;
    apply_reset(4'b1111);
    bus.key_n = 4'b1011;
    tick(2);
    bus.key_n = 4'b0011;
    tick(2);
    for (int e = 0; e < 4; e++) begin
      tick(1);
      tests_run++;
      if (bus.key !== exp_key[e]) begin
        failed++; $display("FAIL stagger_edge%0d: key=%b expected %b", e + 5, bus.key, exp_key[e]);
      end
    end
  endtask

  task automatic test_release();
    apply_reset(4'b1111);
    bus.key_n = 4'b1110;
    tick(10);
    tests_run++;
    if (bus.key !== 4'b0001) begin
      failed++; $display("FAIL release_pre: key=%b expected %b", bus.key, 4'b0001);
    end
    bus.key_n = 4'b1111;
    tick(5);
    tests_run++;
    if (bus.key !== 4'b0001 || bus.key_released !== 4'b0000) begin
      failed++; $display("FAIL release_edge5: key=%b rel=%b expected 0001/0000", bus.key, bus.key_released);
    end
    tick(1);
    tests_run++;
    if (bus.key !== 4'b0000 || bus.key_released !== 4'b0000) begin
      failed++; $display("FAIL release_edge6: key=%b rel=%b expected 0000/0000", bus.key, bus.key_released);
    end
    tick(1);
    tests_run++;
    if (bus.key_released !== REL0) begin
      failed++; $display("FAIL release_pulse: rel=%b expected %b", bus.key_released, REL0);
    end
    tick(1);
    tests_run++;
    if (bus.key_released !== 4'b0000) begin
      failed++; $display("FAIL release_pulse_end: rel=%b expected %b", bus.key_released, 4'b0000);
    end
  endtask

  task automatic test_reset_mid_count();
    apply_reset(4'b1111);
    bus.key_n = 4'b1110;
    tick(3);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.key !== 4'b0000) begin
      failed++; $display("FAIL midreset_async: key=%b expected %b", bus.key, 4'b0000);
    end
    tick(1);
    reset_n = 1'b1;
    tick(5);
    tests_run++;
    if (bus.key !== 4'b0000) begin
      failed++; $display("FAIL midreset_edge5: key=%b expected %b", bus.key, 4'b0000);
    end
    tick(1);
    tests_run++;
    if (bus.key !== 4'b0001) begin
      failed++; $display("FAIL midreset_edge6: key=%b expected %b", bus.key, 4'b0001);
    end
  endtask

  task automatic test_stable_one();
    apply_reset(4'b1111);
    bus1.key_n = 1'b0;
    tick(2);
    tests_run++;
    if (bus1.key !== 1'b0) begin
      failed++; $display("FAIL one_press_edge2: key=%b expected %b", bus1.key, 1'b0);
    end
    tick(1);
    tests_run++;
    if (bus1.key !== 1'b1) begin
      failed++; $display("FAIL one_press_edge3: key=%b expected %b", bus1.key, 1'b1);
    end
    bus1.key_n = 1'b1;
    tick(2);
    tests_run++;
    if (bus1.key !== 1'b1) begin
      failed++; $display("FAIL one_release_edge2: key=%b expected %b", bus1.key, 1'b1);
    end
    tick(1);
    tests_run++;
    if (bus1.key !== 1'b0) begin
      failed++; $display("FAIL one_release_edge3: key=%b expected %b", bus1.key, 1'b0);
    end
  endtask

  initial begin
    tests_run  = 0;
    failed     = 0;
    reset_n    = 1'b0;
    bus.key_n  = 4'b1111;
    bus1.key_n = 1'b1;

    test_reset();
    test_clean_press();
    test_glitch();
    test_staggered();
    test_release();
    test_reset_mid_count();
    test_stable_one();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
